// File: rtl/alu_result_stage.sv
// Result stage behind the 8-bit add/subtract unit: derives N/Z/C/V and buffers results in a 2-entry FIFO.
// Latency one cycle from push to Out_Valid; In_Ready drops only when both entries are occupied.
module alu_result_stage #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_cout,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags,
  output logic             o_sticky_v,
  input  logic             i_clear_sticky,
  output logic [7:0]       o_op_count
);

  localparam int EW = WIDTH + 4;

  logic [EW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic          r_sticky_v;
  logic [7:0]    r_op_count;

  logic          w_push;
  logic          w_pop;
  logic          w_n;
  logic          w_z;
  logic          w_c;
  logic          w_v;
  logic [3:0]    w_flags;
  logic          w_unused;

  // Overflow only needs the operand sign bits; the low bits are carried through the adder's Sum.
  assign w_unused = ^{i_a[WIDTH-2:0], i_b[WIDTH-2:0]};

  assign w_n     = i_sum[WIDTH-1];
  assign w_z     = (i_sum == '0);
  assign w_c     = i_cout ^ i_sub;
  assign w_v     = (i_a[WIDTH-1] == (i_b[WIDTH-1] ^ i_sub)) && (i_sum[WIDTH-1] != i_a[WIDTH-1]);
  assign w_flags = {w_n, w_z, w_c, w_v};

  assign o_in_ready  = (r_count != 2'd2);
  assign o_out_valid = (r_count != 2'd0);
  assign w_push      = i_in_valid && o_in_ready;
  assign w_pop       = o_out_valid && i_out_ready;

  assign o_result   = r_mem[r_rd_ptr][EW-1:4];
  assign o_flags    = r_mem[r_rd_ptr][3:0];
  assign o_sticky_v = r_sticky_v;
  assign o_op_count = r_op_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_sticky_v <= 1'b0;
      r_op_count <= 8'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {i_sum, w_flags};
        r_wr_ptr        <= ~r_wr_ptr;
        r_op_count      <= r_op_count + 8'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      // A new overflow outranks a simultaneous clear.
      if (w_push && w_v) begin
        r_sticky_v <= 1'b1;
      end else if (i_clear_sticky) begin
        r_sticky_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed vectors with hand-computed flags.
module tb_alu_result_stage;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic [7:0] sum;
  logic       cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;
  logic       sticky_v;
  logic       clear_sticky;
  logic [7:0] op_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [11:0] exp_q[$];
  int pop_cyc[$];

  alu_result_stage #(.WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a(a), .i_b(b), .i_sub(sub), .i_sum(sum), .i_cout(cout),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_result(result), .o_flags(flags),
    .o_sticky_v(sticky_v), .i_clear_sticky(clear_sticky), .o_op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: sample at negedge, a pop happens at the following rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("result", int'(result), int'(e[11:4]));
        check("flags", int'(flags), int'(e[3:0]));
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic push(input logic [7:0] ta, input logic [7:0] tb, input logic tsub,
                      input logic [7:0] tsum, input logic tcout, input logic [3:0] tflg,
                      input logic tclr);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    a = ta; b = tb; sub = tsub; sum = tsum; cout = tcout;
    in_valid = 1'b1;
    clear_sticky = tclr;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else n++;
      if (ok) exp_q.push_back({tsum, tflg});
      @(posedge clk);
      #1;
    end
    if (!ok) check("push_timeout", 0, 1);
    in_valid = 1'b0;
    clear_sticky = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_remaining", exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_sticky"}, int'(sticky_v), 0);
    check({tag, "_op_count"}, int'(op_count), 0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_flags"}, int'(flags), 0);
  endtask

  // Asynchronous assertion away from any clock edge; state must clear before the next edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_state(tag);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; sum = '0; cout = 1'b0;
    out_ready = 1'b0; clear_sticky = 1'b0;
    #1;
    check_reset_state("por");
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Add overflow: 0x7F + 0x01
    out_ready = 1'b1;
    push(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 4'b1001, 1'b0);
    check("add_out_valid", int'(out_valid), 1);
    check("add_sticky", int'(sticky_v), 1);
    check("add_op_count", int'(op_count), 1);
    wait_drain();

    // Subtract pair back to back
    push(8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 4'b0100, 1'b0);
    push(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 4'b1010, 1'b0);
    wait_drain();
    check("sub_consecutive", pop_cyc[$] - pop_cyc[$-1], 1);

    // Mid-transaction reset discards a buffered entry
    out_ready = 1'b0;
    push(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 4'b1001, 1'b0);
    check("pre_rst_out_valid", int'(out_valid), 1);
    do_reset("mid_rst");
    check("post_rst_out_valid", int'(out_valid), 0);

    // Backpressure
    out_ready = 1'b0;
    push(8'h11, 8'h00, 1'b0, 8'h11, 1'b0, 4'b0000, 1'b0);
    push(8'h22, 8'h00, 1'b0, 8'h22, 1'b0, 4'b0000, 1'b0);
    a = 8'h33; b = 8'h00; sub = 1'b0; sum = 8'h33; cout = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    check("bp_refused_count", int'(op_count), 2);
    check("bp_still_full", int'(in_ready), 0);
    out_ready = 1'b1;
    push(8'h33, 8'h00, 1'b0, 8'h33, 1'b0, 4'b0000, 1'b0);
    check("bp_op_count", int'(op_count), 3);
    wait_drain();

    // Sticky priority: set beats clear
    check("sticky_initial", int'(sticky_v), 0);
    push(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 4'b1001, 1'b0);
    check("sticky_set", int'(sticky_v), 1);
    push(8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 4'b1001, 1'b1);
    check("sticky_set_wins", int'(sticky_v), 1);
    clear_sticky = 1'b1;
    @(posedge clk);
    #1;
    clear_sticky = 1'b0;
    check("sticky_cleared", int'(sticky_v), 0);
    wait_drain();

    // Counter wrap with unsigned carry
    do_reset("wrap_rst");
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      push(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 4'b0110, 1'b0);
      if (i == 254) check("wrap_count_255", int'(op_count), 255);
    end
    check("wrap_count_0", int'(op_count), 0);
    check("wrap_sticky", int'(sticky_v), 0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage placed directly downstream of the 8-bit ripple-carry add/subtract unit. It captures the adder's sum and carry-out together with the operand sign bits, and derives N/Z/C/V flags. Results are held in a 2-entry buffer behind a valid/ready handshake, so the ALU datapath can stall without losing results. It also keeps a sticky overflow flag and a wrap-around operation counter.

## Interface
- WIDTH, 8, datapath width; must match the adder width.
- Clk  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- In_Valid  input  1  upstream presents a completed adder result this cycle.
- In_Ready  output  1  stage can accept; registered; equals not-full.
- A  input  WIDTH  operand A as fed to the adder.
- B  input  WIDTH  operand B before the subtract inversion.
- Sub  input  1  mode bit; this is the adder's Cin (0 = add, 1 = subtract).
- Sum  input  WIDTH  adder sum output.
- Cout  input  1  adder carry-out.
- Out_Valid  output  1  head entry valid.
- Out_Ready  input  1  downstream consumes the head entry.
- Result  output  WIDTH  head entry sum.
- Flags  output  4  head entry flags {N,Z,C,V}.
- Sticky_V  output  1  set by any accepted overflow; held until cleared.
- Clear_Sticky  input  1  synchronous clear of Sticky_V.
- Op_Count  output  8  number of accepted transactions, modulo 256.

## Operation
- Push occurs when In_Valid && In_Ready. Pop occurs when Out_Valid && Out_Ready.
- Flag computation is combinational at push, from the inputs in the same cycle:
  - N = Sum[WIDTH-1].
  - Z = (Sum == 0).
  - C = Cout XOR Sub. For add, C is the carry. For subtract, C is the borrow (1 when A < B unsigned).
  - V = (A[MSB] == (B[MSB]^Sub)) && (Sum[MSB] != A[MSB]).
- Buffer: a 2-entry FIFO (WIDTH+4 bits per entry) with a write pointer, a read pointer and a 2-bit occupancy count (0..2).
- Result and Flags always show the head entry. When empty, they hold their last value and are undefined for checking; only Out_Valid qualifies them.
- Occupancy update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged. This is legal at occupancy 1. At occupancy 2, push cannot occur because In_Ready = 0.
  - At occupancy 0, a pop cannot occur because Out_Valid = 0.
- In_Ready = (occupancy != 2). Out_Valid = (occupancy != 0). Both are derived from registered state only; there is no combinational path from In_Valid or Out_Ready.
- Sticky_V is set on the cycle after a push with V = 1. Clear_Sticky clears it. If a set and a clear happen in the same cycle, the set wins.
- Op_Count increments by 1 on every push and wraps from 255 to 0. It is not affected by pops.
- Inputs are ignored when In_Valid is 0 or In_Ready is 0, including when values on A/B/Sum change.

## Timing
- Reset (asynchronous, takes effect immediately) sets:
  - occupancy 0, both pointers 0;
  - Out_Valid 0, In_Ready 1;
  - Result 0, Flags 0;
  - Sticky_V 0, Op_Count 0.
- If Reset is asserted mid-transaction, all buffered entries are discarded. No output is emitted for them.
- Latency: a push at edge k makes Out_Valid = 1, with that entry's Result/Flags, after edge k (visible in cycle k+1).
- Throughput: 1 transaction per cycle when Out_Ready is held high.
- Backpressure: with Out_Ready low, 2 pushes fill the buffer, and In_Ready drops in the cycle after the second push.
- After a full-buffer pop, In_Ready returns to 1 in the next cycle. The next push is accepted at the edge after that.
- Ordering is strict FIFO. No entry is dropped or duplicated.

## Test plan
- Reset check: assert Reset asynchronously mid-cycle. Out_Valid=0, In_Ready=1, Sticky_V=0 and Op_Count=0 immediately, with no clock edge needed.
- Add overflow: A=0x7F, B=0x01, Sub=0, Sum=0x80, Cout=0, Out_Ready=1. Next cycle Result=0x80, Flags N=1 Z=0 C=0 V=1. Sticky_V=1, Op_Count=1.
- Subtract cases, back to back:
  - A=0x05, B=0x05, Sub=1, Sum=0x00, Cout=1 gives Flags N=0 Z=1 C=0 V=0.
  - Next cycle, A=0x03, B=0x05, Sub=1, Sum=0xFE, Cout=0 gives Flags N=1 Z=0 C=1 V=0.
  - The two results appear on consecutive cycles.
- Backpressure: Out_Ready=0 and push 0x11, 0x22, 0x33 on consecutive cycles.
  - 0x33 is refused (In_Ready=0) and Op_Count=2.
  - Raise Out_Ready; the outputs are 0x11 then 0x22.
  - Re-presenting 0x33 is accepted after In_Ready returns to 1.
- Sticky priority: with Sticky_V=1, assert Clear_Sticky together with a push having V=1, and Sticky_V stays 1. Next cycle, Clear_Sticky alone gives Sticky_V=0.
- Counter wrap and unsigned carry:
  - 256 pushes of A=0xFF, B=0x01, Sub=0, Sum=0x00, Cout=1.
  - Every entry has Flags N=0 Z=1 C=1 V=0.
  - Op_Count reads 0 after the 256th push.
